button_conditioner: RTL
=======================

Name: button_conditioner

Overview:
- Input-conditioning stage directly upstream of the stopwatch controller and counter-chain clear.
- Takes the three raw, asynchronous, bouncing push-button inputs: start/stop, lap, clear.
- For each button it synchronises to clk, debounces, and produces a clean level plus a one-cycle press pulse.
- The clear button additionally requires a long hold before it issues its clear request, so an accidental tap cannot wipe a running time.

Parameters:
- DEB_CYCLES, 1000000, consecutive clk cycles a synchronised input must differ from the debounced level before that level flips (10 ms at 100 MHz); legal range 2..2^24-1.
- HOLD_CYCLES, 100000000, clk cycles the debounced clear level must stay high before clear_req fires (1 s at 100 MHz); legal range 2..2^28-1.

Ports:
- clk  input  1  system clock, 100 MHz
- res  input  1  asynchronous active-low reset
- btn_in  input  3  raw buttons, active high; [0] start/stop, [1] lap, [2] clear
- btn_level  output  3  debounced button levels
- btn_press  output  3  one-cycle pulse on each debounced rising edge
- clear_req  output  1  one-cycle pulse when the clear button has been held HOLD_CYCLES

Behaviour:
- Reset: res is asynchronous and active-low. While res=0:
  - all synchroniser flops, counters, btn_level, btn_press and clear_req are 0;
  - the hold-armed flag is cleared.
  - Reset asserted mid-debounce or mid-hold abandons that operation; no pulse is emitted after release.
- Synchroniser: two flops per channel, s1<=btn_in, s2<=s1. Every other stage uses only s2.
- Debounce (per channel, independent): the counter cnt has ceil(log2(DEB_CYCLES)) bits.
  - If s2==btn_level: cnt<=0.
  - Else if cnt==DEB_CYCLES-1: btn_level<=s2 and cnt<=0.
  - Else: cnt<=cnt+1.
- Debounce latency: let k be the first edge at which s1 captures a new raw value that then stays stable.
  - btn_level changes at edge k+1+DEB_CYCLES.
  - Any glitch back to the old value before then resets cnt to 0, and the full DEB_CYCLES count restarts.
- Pulses shorter than DEB_CYCLES never reach btn_level.
- btn_press[i]: registered. It is 1 exactly in the cycle following the edge where btn_level[i] goes 0->1, and 0 otherwise. The falling edge produces no pulse.
- Hold logic on channel 2, states IDLE, COUNTING, FIRED:
  - IDLE: when btn_level[2] rises, go to COUNTING with hcnt<=0.
  - COUNTING, btn_level[2]==0: go to IDLE, no pulse.
  - COUNTING, hcnt==HOLD_CYCLES-1: clear_req<=1 for one cycle, go to FIRED.
  - COUNTING, otherwise: hcnt<=hcnt+1.
  - FIRED: stay until btn_level[2]==0, then go to IDLE. There is no auto-repeat while the button remains held.
- Hold latency: clear_req is high in the cycle that begins HOLD_CYCLES edges after the btn_level[2] rising edge.
- btn_press[2] still fires on the initial press.
- Simultaneous presses: channels are fully independent, so any combination of pulses may assert in the same cycle.
- All outputs are registered; there are no combinational paths from btn_in to outputs.

Test Plan:
All scenarios use DEB_CYCLES=4 and HOLD_CYCLES=10.
1. Reset state: with res=0, toggle btn_in freely -> btn_level=000, btn_press=000, clear_req=0 throughout. Release res -> outputs stay 0 while btn_in=000.
2. Clean press: btn_in[0] rises before edge k and is held high -> btn_level[0]=1 from edge k+5, btn_press[0]=1 for exactly one cycle after edge k+5. On release, btn_level[0] falls after 5 edges and no press pulse occurs.
3. Bounce rejection: btn_in[1] pattern high 3 cycles, low 1, high 2, low 1, then steady high -> btn_level[1] rises only 5 edges after the final steady rise. Exactly one btn_press[1] pulse occurs.
4. Short clear: btn_level[2] is held high for 6 cycles, then released -> btn_press[2] pulses once, clear_req stays 0.
5. Long clear: btn_level[2] is held high for 30 cycles -> clear_req pulses exactly once, 10 edges after btn_level[2] rises, with no repeat. Re-pressing after release produces another single pulse.
6. Concurrency and reset abort:
   - Raise btn_in[0] and btn_in[1] on the same edge -> both btn_press bits pulse in the same cycle.
   - Assert res during the hold count -> clear_req never fires.

Source files
------------

// File: rtl/button_conditioner_if.sv
// Button-side bundle of the button conditioner: raw buttons in, conditioned levels and pulses out.
// The master modport is the side that drives the raw buttons; the slave modport is the conditioner.
interface button_conditioner_if;
    logic [2:0] btn_in;
    logic [2:0] btn_level;
    logic [2:0] btn_press;
    logic       clear_req;

    modport master (
        output btn_in,
        input  btn_level,
        input  btn_press,
        input  clear_req
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output btn_press,
        output clear_req
    );
endinterface

// File: rtl/button_conditioner.sv
// Synchronises, debounces and edge-detects three push buttons; the clear button
// additionally needs a long hold before it raises a one-shot clear request.
module button_conditioner #(
    parameter int unsigned DEB_CYCLES  = 1000000,
    parameter int unsigned HOLD_CYCLES = 100000000
) (
    input  logic                 clk,
    input  logic                 res,
    button_conditioner_if.slave  btn
);

    localparam int DEB_W  = (DEB_CYCLES  > 1) ? $clog2(DEB_CYCLES)  : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        COUNTING,
        FIRED
    } hold_state_e;

    logic [2:0]        sync1_q, sync1_d;
    logic [2:0]        sync2_q, sync2_d;
    logic [2:0]        level_q, level_d;
    logic [2:0]        press_q, press_d;
    logic [DEB_W-1:0]  cnt_q [3];
    logic [DEB_W-1:0]  cnt_d [3];

    hold_state_e       state_q, state_d;
    logic [HOLD_W-1:0] hcnt_q, hcnt_d;
    logic              clear_q, clear_d;
    logic              clear_rise;

    // A channel's level only flips after s2 has disagreed with it for DEB_CYCLES straight cycles.
    always_comb begin
        sync1_d = btn.btn_in;
        sync2_d = sync1_q;
        level_d = level_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == DEB_LAST) begin
                    level_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        press_d = level_d & ~level_q;
    end

    // Hold timer starts on the edge the clear level rises, so the request lands HOLD_CYCLES edges later.
    assign clear_rise = level_d[2] & ~level_q[2];

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        clear_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear_rise) begin
                    state_d = COUNTING;
                    hcnt_d  = '0;
                end
            end
            COUNTING: begin
                if (!level_d[2]) begin
                    state_d = IDLE;
                end else if (hcnt_q == HOLD_LAST) begin
                    clear_d = 1'b1;
                    state_d = FIRED;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            FIRED: begin
                if (!level_d[2]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            press_q <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
            state_q <= IDLE;
            hcnt_q  <= '0;
            clear_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            press_q <= press_d;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            clear_q <= clear_d;
        end
    end

    assign btn.btn_level = level_q;
    assign btn.btn_press = press_q;
    assign btn.clear_req = clear_q;

endmodule
